// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and default width for the ALU
// command sequencer.
package alu_pkg;

  localparam int unsigned DATA_W_DEFAULT = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command handshake and completion signals between a command producer and
// the ALU command sequencer.
interface alu_cmd_sequencer_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned REG_AW = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [REG_AW-1:0] cmd_rd;
  logic [REG_AW-1:0] cmd_rs1;
  logic [REG_AW-1:0] cmd_rs2;
  logic              cmd_imm_en;
  logic [DATA_W-1:0] cmd_imm;
  logic              done_valid;
  logic [DATA_W-1:0] done_result;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm,
    input  cmd_ready, done_valid, done_result
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm_en, cmd_imm,
    output cmd_ready, done_valid, done_result
  );
endinterface

// File: rtl/alu_regfile.sv
// Small register file: one synchronous write port, three combinational read
// ports (two operand sources and a debug tap).
module alu_regfile #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic [REG_AW-1:0] raddr3_i,
  output logic [DATA_W-1:0] rdata3_o
);
  logic [DATA_W-1:0] rf_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = rf_q[raddr1_i];
  assign rdata2_o = rf_q[raddr2_i];
  assign rdata3_o = rf_q[raddr3_i];
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Three-cycle command sequencer: reads operands, drives an external ALU,
// captures its outputs and writes the result back with a done pulse.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_sequencer_if.slave cmd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              flag_carry,
  output logic              flag_zero,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  seq_state_e        state_q;
  logic              ready_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q, res_q, done_res_q;
  logic [2:0]        alu_sel_q;
  logic [REG_AW-1:0] rd_q;
  logic              cap_carry_q, cap_zero_q;
  logic              done_valid_q, flag_carry_q, flag_zero_q;
  logic [DATA_W-1:0] rs1_data, rs2_data;
  logic              wr_en;

  assign wr_en = (state_q == ST_CAPTURE);

  alu_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .REG_AW(REG_AW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wr_en),
    .waddr_i  (rd_q),
    .wdata_i  (res_q),
    .raddr1_i (cmd.cmd_rs1),
    .rdata1_o (rs1_data),
    .raddr2_i (cmd.cmd_rs2),
    .rdata2_o (rs2_data),
    .raddr3_i (dbg_addr),
    .rdata3_o (dbg_data)
  );

  // ready_q is a registered copy of "next state is IDLE", so it stays low
  // through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rd_q         <= '0;
      res_q        <= '0;
      cap_carry_q  <= 1'b0;
      cap_zero_q   <= 1'b0;
      done_valid_q <= 1'b0;
      done_res_q   <= '0;
      flag_carry_q <= 1'b0;
      flag_zero_q  <= 1'b0;
    end else begin
      done_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd.cmd_valid && ready_q) begin
            alu_a_q   <= rs1_data;
            alu_b_q   <= cmd.cmd_imm_en ? cmd.cmd_imm : rs2_data;
            alu_sel_q <= cmd.cmd_op;
            rd_q      <= cmd.cmd_rd;
            ready_q   <= 1'b0;
            state_q   <= ST_ISSUE;
          end else begin
            ready_q   <= 1'b1;
          end
        end
        ST_ISSUE: begin
          res_q       <= alu_result;
          cap_carry_q <= alu_carry;
          cap_zero_q  <= alu_zero;
          state_q     <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          flag_carry_q <= cap_carry_q;
          flag_zero_q  <= cap_zero_q;
          done_res_q   <= res_q;
          done_valid_q <= 1'b1;
          ready_q      <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd.cmd_ready   = ready_q;
  assign cmd.done_valid  = done_valid_q;
  assign cmd.done_result = done_res_q;
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_sel         = alu_sel_q;
  assign flag_carry      = flag_carry_q;
  assign flag_zero       = flag_zero_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a 4-bit ALU alongside it.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic       alu_carry, alu_zero;
  logic       flag_carry, flag_zero;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
  int         vectors = 0;
  int         errors  = 0;

  alu_cmd_sequencer_if #(.DATA_W(4), .REG_AW(2)) cif ();

  alu_cmd_sequencer #(.DATA_W(4), .NREGS(4), .REG_AW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cif.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  // The 4-bit ALU that sits next to the sequencer in the parent design.
  always_comb begin
    logic [4:0] sum;
    sum        = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_sel)
      OP_ADD: {alu_carry, alu_result} = sum;
      OP_SUB: alu_result = alu_a - alu_b;
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_NOT: alu_result = ~alu_a;
      OP_SHL: alu_result = alu_a << 1;
      OP_SHR: alu_result = alu_a >> 1;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 4'h0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic ie, input logic [3:0] imm);
    cif.cmd_valid  = 1'b1;
    cif.cmd_op     = op;
    cif.cmd_rd     = rd;
    cif.cmd_rs1    = rs1;
    cif.cmd_rs2    = rs2;
    cif.cmd_imm_en = ie;
    cif.cmd_imm    = imm;
  endtask

  // Called at a negedge with cmd_ready high and a command driven: handshake
  // at the next posedge, done expected on the third following negedge.
  task automatic expect_done(input string tag, input logic [3:0] res, input logic c,
                             input logic z, input bit hold_valid);
    @(posedge clk);
    @(negedge clk);
    check({tag, " ready_issue"}, 32'(cif.cmd_ready), 32'd0);
    check({tag, " done_issue"}, 32'(cif.done_valid), 32'd0);
    if (!hold_valid) cif.cmd_valid = 1'b0;
    @(negedge clk);
    check({tag, " done_capture"}, 32'(cif.done_valid), 32'd0);
    @(negedge clk);
    check({tag, " done"}, 32'(cif.done_valid), 32'd1);
    check({tag, " result"}, 32'(cif.done_result), 32'(res));
    check({tag, " carry"}, 32'(flag_carry), 32'(c));
    check({tag, " zero"}, 32'(flag_zero), 32'(z));
    check({tag, " ready_done"}, 32'(cif.cmd_ready), 32'd1);
  endtask

  task automatic check_reg(input string tag, input logic [1:0] addr, input logic [3:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, 32'(dbg_data), 32'(exp));
  endtask

  initial begin
    rst_n          = 1'b0;
    dbg_addr       = '0;
    cif.cmd_valid  = 1'b0;
    cif.cmd_op     = '0;
    cif.cmd_rd     = '0;
    cif.cmd_rs1    = '0;
    cif.cmd_rs2    = '0;
    cif.cmd_imm_en = 1'b0;
    cif.cmd_imm    = '0;

    // Power-on reset
    repeat (2) @(negedge clk);
    check("rst ready", 32'(cif.cmd_ready), 32'd0);
    check("rst alu_a", 32'(alu_a), 32'd0);
    check("rst done", 32'(cif.done_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel ready", 32'(cif.cmd_ready), 32'd1);

    // Reset asserted while the command sits in ISSUE
    drive(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'h7);
    @(posedge clk);
    @(negedge clk);
    check("issue alu_b", 32'(alu_b), 32'h7);
    check("issue ready", 32'(cif.cmd_ready), 32'd0);
    cif.cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort alu_a", 32'(alu_a), 32'd0);
    check("abort alu_b", 32'(alu_b), 32'd0);
    check("abort alu_sel", 32'(alu_sel), 32'd0);
    check("abort ready", 32'(cif.cmd_ready), 32'd0);
    check("abort done", 32'(cif.done_valid), 32'd0);
    check("abort dres", 32'(cif.done_result), 32'd0);
    check("abort flags", 32'({flag_carry, flag_zero}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel2 ready", 32'(cif.cmd_ready), 32'd1);
    check("rel2 done", 32'(cif.done_valid), 32'd0);
    check_reg("abort r1", 2'd1, 4'h0);

    // Immediate loads and add with carry out
    drive(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'h9);
    expect_done("ld r1", 4'h9, 1'b0, 1'b0, 1'b0);
    drive(OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 4'h8);
    expect_done("ld r2", 4'h8, 1'b0, 1'b0, 1'b0);
    drive(OP_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 4'h0);
    expect_done("add", 4'h1, 1'b1, 1'b0, 1'b0);
    check_reg("add r3", 2'd3, 4'h1);

    // Zero results; non-add clears carry
    drive(OP_SUB, 2'd3, 2'd1, 2'd1, 1'b0, 4'h0);
    expect_done("sub", 4'h0, 1'b0, 1'b1, 1'b0);
    drive(OP_AND, 2'd0, 2'd1, 2'd0, 1'b1, 4'h6);
    expect_done("and", 4'h0, 1'b0, 1'b1, 1'b0);
    check("idle hold sel", 32'(alu_sel), 32'(OP_AND));

    // Back-to-back with cmd_valid held; second and third read fresh results
    drive(OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 4'h3);
    expect_done("b2b0", 4'h3, 1'b0, 1'b0, 1'b1);
    drive(OP_ADD, 2'd3, 2'd2, 2'd0, 1'b1, 4'h4);
    expect_done("b2b1", 4'h7, 1'b0, 1'b0, 1'b1);
    drive(OP_XOR, 2'd1, 2'd3, 2'd2, 1'b0, 4'h0);
    expect_done("b2b2", 4'h4, 1'b0, 1'b0, 1'b1);
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b no4th", 32'(cif.done_valid), 32'd0);
    check_reg("b2b r1", 2'd1, 4'h4);

    // Destination equals source; MSB shifted out
    drive(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 4'h5);
    expect_done("ld5", 4'h5, 1'b0, 1'b0, 1'b0);
    drive(OP_SHL, 2'd1, 2'd1, 2'd0, 1'b0, 4'h0);
    expect_done("shl1", 4'hA, 1'b0, 1'b0, 1'b0);
    drive(OP_SHL, 2'd1, 2'd1, 2'd0, 1'b0, 4'h0);
    expect_done("shl2", 4'h4, 1'b0, 1'b0, 1'b0);

    // cmd_valid pulsed while busy is ignored
    drive(OP_SUB, 2'd2, 2'd3, 2'd2, 1'b0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    drive(OP_OR, 2'd0, 2'd1, 2'd0, 1'b1, 4'hF);
    @(negedge clk);
    check("busy done", 32'(cif.done_valid), 32'd0);
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    check("busy done1", 32'(cif.done_valid), 32'd1);
    check("busy result", 32'(cif.done_result), 32'h4);
    @(negedge clk);
    check("busy no extra", 32'(cif.done_valid), 32'd0);
    check("busy sel", 32'(alu_sel), 32'(OP_SUB));
    check_reg("busy r0", 2'd0, 4'h0);
    check_reg("busy r2", 2'd2, 4'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end
endmodule
